// File: rtl/hop_bits_loader.sv
// hop_bits_loader: assembles 32-bit AXI-Stream hop-pattern words into a
// 128-bit shadow frame and hands it to the scan controller's tx_bits bus at
// each rising edge of hop_rst. It also flags framing errors and underruns.
// Optional feature macro: HOP_LOADER_STATS_EN enables the frames_sent
// counter, the ntx_bits_cnt history register and the underrun flag. When it
// is undefined, those outputs are tied to zero.
module hop_bits_loader #(
    parameter int WORD_WIDTH      = 32,
    parameter int TX_BITS_WIDTH   = 128,
    parameter int WORDS_PER_FRAME = 4,
    parameter int BIT_CNT_WIDTH   = 7,
    parameter int NTX_BITS        = 78,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WORD_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    input  logic                     hop_rst,
    input  logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt,
    output logic [TX_BITS_WIDTH-1:0] tx_bits,
    output logic                     frame_pending,
    output logic [CNT_WIDTH-1:0]     frames_sent,
    output logic                     underrun,
    output logic                     err_len
);

    localparam int IDX_W = (WORDS_PER_FRAME > 1) ? $clog2(WORDS_PER_FRAME) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        DROP = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     shadow_we;
    logic                     set_err;
    logic [TX_BITS_WIDTH-1:0] shadow;
    logic                     hop_rst_q;
    logic                     accept;
    logic                     transfer;

    // A word is accepted in FILL or DROP, and never while reset is asserted.
    assign s_tready      = ~reset & (state_q != FULL);
    assign frame_pending = (state_q == FULL);
    assign accept        = s_tvalid & s_tready;
    // The transfer point is a rising edge of hop_rst.
    assign transfer      = hop_rst & ~hop_rst_q;

    // Next-state logic. The transfer decision uses the state at the start of the cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_d   = state_q;
        idx_d     = idx_q;
        shadow_we = 1'b0;
        set_err   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    shadow_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (s_tlast) begin
                            state_d = FULL;
                        end else begin
                            // The frame is too long, so discard words up to the next tlast.
                            set_err = 1'b1;
                            state_d = DROP;
                        end
                    end else if (s_tlast) begin
                        // The frame is too short, so the partial frame is abandoned.
                        set_err = 1'b1;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    state_d = FILL;
                    idx_d   = '0;
                end
            end
            FULL: begin
                if (transfer) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
                idx_d   = '0;
            end
        endcase
    end

    // Registers for the state, the word index, the active frame and the framing flag.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
        if (reset) begin
            state_q   <= FILL;
            idx_q     <= '0;
            hop_rst_q <= 1'b0;
            tx_bits   <= '0;
            err_len   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hop_rst_q <= hop_rst;
            if (transfer && state_q == FULL) begin
                tx_bits <= shadow;
            end
            if (set_err) begin
                err_len <= 1'b1;
            end
        end
    end

    // Shadow frame storage. Word k is written into slice k, so word 0 sits in the LSBs.
    always_ff @(posedge clk) begin
        // NOTE: the shadow is left out of reset on purpose. It is only visible after a full refill.
        if (shadow_we) begin
            shadow[idx_q*WORD_WIDTH +: WORD_WIDTH] <= s_tdata;
        end
    end

`ifdef HOP_LOADER_STATS_EN
    logic [BIT_CNT_WIDTH-1:0] ntx_bits_cnt_q;
    logic                     done_pulse;

    // A transmission completes when the bit counter first reaches NTX_BITS while hop_rst is low.
    assign done_pulse = (ntx_bits_cnt == BIT_CNT_WIDTH'(NTX_BITS)) &&
                        (ntx_bits_cnt_q != BIT_CNT_WIDTH'(NTX_BITS)) && !hop_rst;

    // Statistics: the completion counter, which wraps, and the sticky underrun flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            ntx_bits_cnt_q <= '0;
            frames_sent    <= '0;
            underrun       <= 1'b0;
        end else begin
            ntx_bits_cnt_q <= ntx_bits_cnt;
            if (done_pulse) begin
                frames_sent <= frames_sent + 1'b1;
            end
            if (transfer && state_q != FULL) begin
                underrun <= 1'b1;
            end
        end
    end
`else
    logic unused_ntx_bits_cnt;
    assign unused_ntx_bits_cnt = ^ntx_bits_cnt;
    assign frames_sent         = '0;
    assign underrun            = 1'b0;
`endif

endmodule

// File: doc/hop_bits_loader.md
# hop_bits_loader

Upstream feeder for the main ANC transmit controller's hop scan chain. It accepts hop-pattern words from the host over a 32-bit AXI-Stream and assembles them into a 128-bit frame in a shadow register. At the start of each sync sequence (`hop_rst` rising) it transfers that frame, glitch-free, to the `tx_bits` bus that the scan controller shifts out. It also counts completed scan transmissions and flags underruns and framing errors back to the host.

## Interface
- `WORD_WIDTH`, 32: stream word width.
- `TX_BITS_WIDTH`, 128: frame width. Must equal `WORDS_PER_FRAME*WORD_WIDTH`.
- `WORDS_PER_FRAME`, 4: words per frame.
- `BIT_CNT_WIDTH`, 7: width of the scan bit counter input.
- `NTX_BITS`, 78: scan bit count that marks a completed transmission.
- `CNT_WIDTH`, 16: width of the `frames_sent` counter.

Ports:
- `clk`  in  1  system clock (same domain as the transmit controller).
- `reset`  in  1  synchronous, active-high reset.
- `s_tdata`  in  WORD_WIDTH  host word.
- `s_tvalid`  in  1  word valid.
- `s_tlast`  in  1  last word of frame.
- `s_tready`  out  1  word accepted when `s_tvalid & s_tready`.
- `hop_rst`  in  1  scan-chain reset from the transmit controller; synchronous to `clk`.
- `ntx_bits_cnt`  in  BIT_CNT_WIDTH  scan bit counter from the transmit controller.
- `tx_bits`  out  TX_BITS_WIDTH  active frame driven to the scan controller.
- `frame_pending`  out  1  shadow frame complete and awaiting transfer.
- `frames_sent`  out  CNT_WIDTH  count of completed transmissions.
- `underrun`  out  1  sticky flag: a transfer point occurred with no frame pending.
- `err_len`  out  1  sticky flag: framing error.

## Operation
- Reset values:
  - `tx_bits` = 0, `frames_sent` = 0, `underrun` = 0, `err_len` = 0, `frame_pending` = 0.
  - State = FILL, word index = 0.
  - `s_tready` = 0 while `reset` is high.
- FILL state:
  - `s_tready` = 1.
  - An accepted word at index k is written to `shadow[k*WORD_WIDTH +: WORD_WIDTH]` (word 0 fills the LSBs), then k increments.
  - Word at index `WORDS_PER_FRAME-1` with `s_tlast` = 1: go to FULL, k = 0.
  - `s_tlast` = 1 at any lower index: set `err_len`, k = 0, stay in FILL. The partial frame is discarded.
  - Word at the last index with `s_tlast` = 0: set `err_len`, go to DROP.
- DROP state: `s_tready` = 1. Words are discarded. On an accepted word with `s_tlast` = 1, go to FILL with k = 0.
- FULL state: `s_tready` = 0 and `frame_pending` = 1.
- Transfer point: a cycle where `hop_rst` = 1 and the registered previous `hop_rst` = 0.
  - If state is FULL: `tx_bits` <= shadow, state <= FILL.
  - Otherwise: set `underrun`. `tx_bits` holds its previous frame, so the last pattern repeats.
- Simultaneous events:
  - The transfer decision uses the state at the start of the cycle.
  - If the final word is accepted in the same cycle as the transfer point, this is an underrun. That frame enters FULL and is used at the next transfer point.
- Completion: `frames_sent` increments when `ntx_bits_cnt == NTX_BITS`, the previous registered `ntx_bits_cnt != NTX_BITS`, and `hop_rst` = 0.
  - The counter wraps modulo 2^CNT_WIDTH.
- `tx_bits` changes only at a transfer point, and `hop_rst` is high at that moment. The scan controller is therefore held in reset whenever its input changes.
- Reset mid-frame: everything returns to reset values and the partial shadow contents are discarded. The shadow register is not cleared, but it is unreachable until refilled.

## Timing
- Stream: one word per cycle at full rate in FILL and DROP.
- `s_tready` is combinational from state (and low during `reset`).
- Transfer: if the transfer point is sampled in cycle N, `tx_bits` is new and `frame_pending` = 0 in cycle N+1. `s_tready` = 1 in cycle N+1.
- Fastest refill: 4 cycles after transfer, `frame_pending` = 1 again.
- Flags and counter: updated one cycle after the qualifying input cycle.

## Configuration
- `HOP_LOADER_STATS_EN`:
  - Defined: the `frames_sent` counter, the `ntx_bits_cnt` history register, and the `underrun` flag are implemented as above.
  - Undefined: `frames_sent` = 0 and `underrun` = 0 constantly, and their logic is removed. `ntx_bits_cnt` is ignored. Transfer and `err_len` behaviour are unchanged.

## Test plan
- Send 0x11111111, 0x22222222, 0x33333333, 0x44444444 with `tlast` on the fourth word, then pulse `hop_rst` -> `tx_bits` = 0x44444444_33333333_22222222_11111111 one cycle after the rising edge; `frame_pending` is 1→0.
- Pulse `hop_rst` with no frame loaded after reset -> `underrun` = 1, `tx_bits` stays 0.
- Send 2 words with `tlast` on the second -> `err_len` = 1, `frame_pending` = 0. Then send a valid 4-word frame -> FULL.
- Send 5 words with `tlast` only on the fifth -> `err_len` = 1, all 5 words dropped, `frame_pending` = 0. Next valid frame loads correctly.
- With `hop_rst` low, ramp `ntx_bits_cnt` 0..78 and hold at 78 for 10 cycles, twice -> `frames_sent` = 2. Repeat the ramp with `hop_rst` high -> no increment.
- Assert `reset` after 3 words, then send a full frame and pulse `hop_rst` -> only the new frame appears on `tx_bits`, and no `err_len` is flagged.
